// File: rtl/kamus_ex.sv
// KAMUS execute stage: forwarding muxes, ALU, branch resolution, a 1-bit-per-cycle
// shift-add multiplier, and the EX/MEM pipeline register.
package kamus_pkg;
    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_SLL   = 5'd2,  OP_SLT   = 5'd3,
        OP_SLTU  = 5'd4,  OP_XOR   = 5'd5,  OP_SRL   = 5'd6,  OP_SRA   = 5'd7,
        OP_OR    = 5'd8,  OP_AND   = 5'd9,  OP_ADDI  = 5'd10, OP_SLTI  = 5'd11,
        OP_SLTIU = 5'd12, OP_XORI  = 5'd13, OP_ORI   = 5'd14, OP_ANDI  = 5'd15,
        OP_SLLI  = 5'd16, OP_SRLI  = 5'd17, OP_SRAI  = 5'd18, OP_LOAD  = 5'd19,
        OP_STORE = 5'd20, OP_LUI   = 5'd21, OP_AUIPC = 5'd22, OP_JAL   = 5'd23,
        OP_JALR  = 5'd24, OP_BEQ   = 5'd25, OP_BNE   = 5'd26, OP_BLT   = 5'd27,
        OP_BGE   = 5'd28, OP_BLTU  = 5'd29, OP_BGEU  = 5'd30, OP_MUL   = 5'd31
    } op_e;

    typedef enum logic {S_IDLE, S_BUSY} mul_state_e;
endpackage

module kamus_ex
    import kamus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_idex_reg_i,
    input  logic [31:0] rs1_data_idex_reg_i,
    input  logic [31:0] rs2_data_idex_reg_i,
    input  logic [31:0] imm_idex_reg_i,
    input  logic [31:0] pc_idex_reg_i,
    input  logic [4:0]  operation_idex_reg_i,
    input  logic        l1d_wr_en_idex_reg_i,
    input  logic        regfile_wr_en_idex_reg_i,
    input  logic [1:0]  wb_mux_sel_idex_reg_i,
    input  logic [4:0]  rd_addr_idex_reg_i,
    input  logic [1:0]  fwd_a_sel_i,
    input  logic [1:0]  fwd_b_sel_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] rs2_data_exmem_reg_o,
    output logic [31:0] alu_rslt_exmem_reg_o,
    output logic        l1d_wr_en_exmem_reg_o,
    output logic        regfile_wr_en_exmem_reg_o,
    output logic [1:0]  wb_mux_sel_exmem_reg_o,
    output logic [4:0]  rd_addr_exmem_reg_o,
    output logic [4:0]  operation_exmem_reg_o,
    output logic        branch_taken_o,
    output logic [31:0] branch_target_o,
    output logic        stall_o
);

    op_e         op;
    logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_rslt, mul_prod, pc_plus4;
    logic        take;
    logic        stall;

    mul_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;

    logic [31:0] rs2_q, rs2_d, alu_rslt_q, alu_rslt_d;
    logic        l1d_wr_en_q, l1d_wr_en_d, rf_wr_en_q, rf_wr_en_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic [4:0]  rd_q, rd_d, op_q, op_d;

    assign op       = op_e'(operation_idex_reg_i);
    assign pc_plus4 = pc_idex_reg_i + 32'd4;
    assign mul_prod = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    // Code 11 on either select is reserved and falls back to the ID/EX operand.
    always_comb begin
        case (fwd_a_sel_i)
            2'b01:   rs1_fwd = alu_rslt_q;
            2'b10:   rs1_fwd = wb_data_i;
            default: rs1_fwd = rs1_data_idex_reg_i;
        endcase
        case (fwd_b_sel_i)
            2'b01:   rs2_fwd = alu_rslt_q;
            2'b10:   rs2_fwd = wb_data_i;
            default: rs2_fwd = rs2_data_idex_reg_i;
        endcase
        op_a = (op == OP_AUIPC || op == OP_JAL) ? pc_idex_reg_i : rs1_fwd;
        op_b = (op inside {[OP_ADDI:OP_SRAI], OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JALR})
               ? imm_idex_reg_i : rs2_fwd;
    end

    always_comb begin
        case (op)
            OP_ADD, OP_ADDI, OP_LOAD, OP_STORE, OP_AUIPC: alu_rslt = op_a + op_b;
            OP_SUB:            alu_rslt = op_a - op_b;
            OP_SLL, OP_SLLI:   alu_rslt = op_a << op_b[4:0];
            OP_SLT, OP_SLTI:   alu_rslt = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU, OP_SLTIU: alu_rslt = {31'd0, op_a < op_b};
            OP_XOR, OP_XORI:   alu_rslt = op_a ^ op_b;
            OP_SRL, OP_SRLI:   alu_rslt = op_a >> op_b[4:0];
            OP_SRA, OP_SRAI:   alu_rslt = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_OR, OP_ORI:     alu_rslt = op_a | op_b;
            OP_AND, OP_ANDI:   alu_rslt = op_a & op_b;
            OP_LUI:            alu_rslt = imm_idex_reg_i;
            OP_JAL, OP_JALR:   alu_rslt = pc_plus4;
            OP_MUL:            alu_rslt = mul_prod;
            default:           alu_rslt = 32'd0;
        endcase
    end

    always_comb begin
        take            = 1'b0;
        branch_target_o = pc_idex_reg_i + imm_idex_reg_i;
        case (op)
            OP_BEQ:  take = (rs1_fwd == rs2_fwd);
            OP_BNE:  take = (rs1_fwd != rs2_fwd);
            OP_BLT:  take = ($signed(rs1_fwd) <  $signed(rs2_fwd));
            OP_BGE:  take = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            OP_BLTU: take = (rs1_fwd <  rs2_fwd);
            OP_BGEU: take = (rs1_fwd >= rs2_fwd);
            OP_JAL:  take = 1'b1;
            OP_JALR: begin
                take            = 1'b1;
                branch_target_o = (rs1_fwd + imm_idex_reg_i) & ~32'd1;
            end
            default: take = 1'b0;
        endcase
        branch_taken_o = take && valid_idex_reg_i && !stall;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        stall    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_idex_reg_i && op == OP_MUL) begin
                    stall    = 1'b1;
                    state_d  = S_BUSY;
                    cnt_d    = 6'd32;
                    mcand_d  = rs1_fwd;
                    mplier_d = rs2_fwd;
                    acc_d    = 32'd0;
                end
            end
            S_BUSY: begin
                // The last step is folded into mul_prod, which EX/MEM captures directly.
                stall    = (cnt_q != 6'd1);
                acc_d    = mul_prod;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rs2_d       = rs2_q;
        alu_rslt_d  = alu_rslt_q;
        l1d_wr_en_d = 1'b0;
        rf_wr_en_d  = 1'b0;
        wb_sel_d    = wb_sel_q;
        rd_d        = rd_q;
        op_d        = op_q;
        if (valid_idex_reg_i && !stall) begin
            rs2_d       = rs2_fwd;
            alu_rslt_d  = alu_rslt;
            l1d_wr_en_d = l1d_wr_en_idex_reg_i;
            rf_wr_en_d  = regfile_wr_en_idex_reg_i;
            wb_sel_d    = wb_mux_sel_idex_reg_i;
            rd_d        = rd_addr_idex_reg_i;
            op_d        = operation_idex_reg_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            mcand_q     <= 32'd0;
            mplier_q    <= 32'd0;
            acc_q       <= 32'd0;
            rs2_q       <= 32'd0;
            alu_rslt_q  <= 32'd0;
            l1d_wr_en_q <= 1'b0;
            rf_wr_en_q  <= 1'b0;
            wb_sel_q    <= 2'd0;
            rd_q        <= 5'd0;
            op_q        <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            rs2_q       <= rs2_d;
            alu_rslt_q  <= alu_rslt_d;
            l1d_wr_en_q <= l1d_wr_en_d;
            rf_wr_en_q  <= rf_wr_en_d;
            wb_sel_q    <= wb_sel_d;
            rd_q        <= rd_d;
            op_q        <= op_d;
        end
    end

    assign stall_o                   = stall;
    assign rs2_data_exmem_reg_o      = rs2_q;
    assign alu_rslt_exmem_reg_o      = alu_rslt_q;
    assign l1d_wr_en_exmem_reg_o     = l1d_wr_en_q;
    assign regfile_wr_en_exmem_reg_o = rf_wr_en_q;
    assign wb_mux_sel_exmem_reg_o    = wb_sel_q;
    assign rd_addr_exmem_reg_o       = rd_q;
    assign operation_exmem_reg_o     = op_q;

endmodule

// File: tb/tb_kamus_ex.sv
// Directed self-checking bench for kamus_ex: ALU, forwarding, branches, bubbles,
// the multi-cycle multiplier and reset during a multiply.
module tb_kamus_ex;
    import kamus_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        valid_idex_reg_i = 1'b0;
    logic [31:0] rs1_data_idex_reg_i = '0, rs2_data_idex_reg_i = '0;
    logic [31:0] imm_idex_reg_i = '0, pc_idex_reg_i = '0;
    logic [4:0]  operation_idex_reg_i = '0;
    logic        l1d_wr_en_idex_reg_i = 1'b0, regfile_wr_en_idex_reg_i = 1'b0;
    logic [1:0]  wb_mux_sel_idex_reg_i = '0;
    logic [4:0]  rd_addr_idex_reg_i = '0;
    logic [1:0]  fwd_a_sel_i = '0, fwd_b_sel_i = '0;
    logic [31:0] wb_data_i = '0;
    logic [31:0] rs2_data_exmem_reg_o, alu_rslt_exmem_reg_o, branch_target_o;
    logic        l1d_wr_en_exmem_reg_o, regfile_wr_en_exmem_reg_o, branch_taken_o, stall_o;
    logic [1:0]  wb_mux_sel_exmem_reg_o;
    logic [4:0]  rd_addr_exmem_reg_o, operation_exmem_reg_o;

    int tests = 0;
    int errors = 0;

    kamus_ex dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_idex_reg_i(valid_idex_reg_i),
        .rs1_data_idex_reg_i(rs1_data_idex_reg_i), .rs2_data_idex_reg_i(rs2_data_idex_reg_i),
        .imm_idex_reg_i(imm_idex_reg_i), .pc_idex_reg_i(pc_idex_reg_i),
        .operation_idex_reg_i(operation_idex_reg_i), .l1d_wr_en_idex_reg_i(l1d_wr_en_idex_reg_i),
        .regfile_wr_en_idex_reg_i(regfile_wr_en_idex_reg_i),
        .wb_mux_sel_idex_reg_i(wb_mux_sel_idex_reg_i), .rd_addr_idex_reg_i(rd_addr_idex_reg_i),
        .fwd_a_sel_i(fwd_a_sel_i), .fwd_b_sel_i(fwd_b_sel_i), .wb_data_i(wb_data_i),
        .rs2_data_exmem_reg_o(rs2_data_exmem_reg_o), .alu_rslt_exmem_reg_o(alu_rslt_exmem_reg_o),
        .l1d_wr_en_exmem_reg_o(l1d_wr_en_exmem_reg_o),
        .regfile_wr_en_exmem_reg_o(regfile_wr_en_exmem_reg_o),
        .wb_mux_sel_exmem_reg_o(wb_mux_sel_exmem_reg_o), .rd_addr_exmem_reg_o(rd_addr_exmem_reg_o),
        .operation_exmem_reg_o(operation_exmem_reg_o), .branch_taken_o(branch_taken_o),
        .branch_target_o(branch_target_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_instr(input op_e op, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                             input logic l1d, input logic rf);
        valid_idex_reg_i         = 1'b1;
        operation_idex_reg_i     = op;
        rs1_data_idex_reg_i      = rs1;
        rs2_data_idex_reg_i      = rs2;
        imm_idex_reg_i           = imm;
        pc_idex_reg_i            = pc;
        rd_addr_idex_reg_i       = rd;
        l1d_wr_en_idex_reg_i     = l1d;
        regfile_wr_en_idex_reg_i = rf;
        wb_mux_sel_idex_reg_i    = 2'b01;
        fwd_a_sel_i              = 2'b00;
        fwd_b_sel_i              = 2'b00;
    endtask

    task automatic test_reset();
        rst_ni = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        tests++;
        if ({rs2_data_exmem_reg_o, alu_rslt_exmem_reg_o, l1d_wr_en_exmem_reg_o,
             regfile_wr_en_exmem_reg_o, wb_mux_sel_exmem_reg_o, rd_addr_exmem_reg_o,
             operation_exmem_reg_o, stall_o, branch_taken_o} !== '0) begin
            $display("FAIL reset_outputs: alu=%h rs2=%h stall=%b", alu_rslt_exmem_reg_o,
                     rs2_data_exmem_reg_o, stall_o);
            errors++;
        end
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_add();
        set_instr(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1);
        #1;
        tests++;
        if (branch_taken_o !== 1'b0) begin
            $display("FAIL add_no_branch: got %b expected 0", branch_taken_o); errors++;
        end
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'h8000_0000 || regfile_wr_en_exmem_reg_o !== 1'b1 ||
            rd_addr_exmem_reg_o !== 5'd5 || operation_exmem_reg_o !== OP_ADD ||
            wb_mux_sel_exmem_reg_o !== 2'b01) begin
            $display("FAIL add_overflow: got alu=%h rf=%b rd=%0d expected alu=80000000 rf=1 rd=5",
                     alu_rslt_exmem_reg_o, regfile_wr_en_exmem_reg_o, rd_addr_exmem_reg_o);
            errors++;
        end
    endtask

    task automatic test_forward();
        set_instr(OP_ADDI, 32'd4, 32'd0, 32'd6, 32'h0, 5'd1, 1'b0, 1'b1);
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'd10) begin
            $display("FAIL addi: got %h expected 0000000a", alu_rslt_exmem_reg_o); errors++;
        end
        set_instr(OP_SUB, 32'd999, 32'd3, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1);
        fwd_a_sel_i = 2'b01;
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'd7) begin
            $display("FAIL fwd_a_exmem: got %h expected 00000007", alu_rslt_exmem_reg_o); errors++;
        end
        set_instr(OP_ADDI, 32'd4, 32'd0, 32'd6, 32'h0, 5'd1, 1'b0, 1'b1);
        tick();
        set_instr(OP_SUB, 32'd999, 32'd999, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1);
        fwd_a_sel_i = 2'b01;
        fwd_b_sel_i = 2'b10;
        wb_data_i   = 32'd5;
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'd5) begin
            $display("FAIL fwd_b_wb: got %h expected 00000005", alu_rslt_exmem_reg_o); errors++;
        end
        set_instr(OP_ADD, 32'd1, 32'd2, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1);
        fwd_a_sel_i = 2'b11;
        fwd_b_sel_i = 2'b11;
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'd3) begin
            $display("FAIL fwd_reserved: got %h expected 00000003", alu_rslt_exmem_reg_o); errors++;
        end
    endtask

    task automatic test_alu_ops();
        op_e         ops [7] = '{OP_SRA, OP_SRL, OP_SLT, OP_SLTU, OP_SLTIU, OP_XORI, OP_SLLI};
        logic [31:0] a   [7] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h1, 32'hFF00_FF00, 32'h1};
        logic [31:0] b   [7] = '{32'h24, 32'h21, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0};
        logic [31:0] im  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1F};
        logic [31:0] exp [7] = '{32'hF800_0000, 32'h4000_0000, 32'h1, 32'h0, 32'h1,
                                 32'h00FF_00FF, 32'h8000_0000};
        for (int i = 0; i < 7; i++) begin
            set_instr(ops[i], a[i], b[i], im[i], 32'h0, 5'd4, 1'b0, 1'b1);
            tick();
            tests++;
            if (alu_rslt_exmem_reg_o !== exp[i]) begin
                $display("FAIL alu_op%0d: got %h expected %h", i, alu_rslt_exmem_reg_o, exp[i]);
                errors++;
            end
        end
        set_instr(OP_LUI, 32'h5, 32'h0, 32'h1234_5000, 32'h0, 5'd6, 1'b0, 1'b1);
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'h1234_5000) begin
            $display("FAIL lui: got %h expected 12345000", alu_rslt_exmem_reg_o); errors++;
        end
        set_instr(OP_AUIPC, 32'h5, 32'h0, 32'h1000, 32'h200, 5'd6, 1'b0, 1'b1);
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'h1200) begin
            $display("FAIL auipc: got %h expected 00001200", alu_rslt_exmem_reg_o); errors++;
        end
        set_instr(OP_STORE, 32'h100, 32'hABCD, 32'h8, 32'h0, 5'd0, 1'b1, 1'b0);
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'h108 || rs2_data_exmem_reg_o !== 32'hABCD ||
            l1d_wr_en_exmem_reg_o !== 1'b1 || regfile_wr_en_exmem_reg_o !== 1'b0) begin
            $display("FAIL store: got addr=%h data=%h l1d=%b rf=%b expected 108 abcd 1 0",
                     alu_rslt_exmem_reg_o, rs2_data_exmem_reg_o, l1d_wr_en_exmem_reg_o,
                     regfile_wr_en_exmem_reg_o);
            errors++;
        end
    endtask

    task automatic test_bubble();
        set_instr(OP_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1);
        valid_idex_reg_i = 1'b0;
        tick();
        tests++;
        if (l1d_wr_en_exmem_reg_o !== 1'b0 || regfile_wr_en_exmem_reg_o !== 1'b0 ||
            alu_rslt_exmem_reg_o !== 32'h108 || rd_addr_exmem_reg_o !== 5'd0 ||
            rs2_data_exmem_reg_o !== 32'hABCD) begin
            $display("FAIL invalid_bubble: got l1d=%b rf=%b alu=%h rd=%0d expected 0 0 108 0",
                     l1d_wr_en_exmem_reg_o, regfile_wr_en_exmem_reg_o, alu_rslt_exmem_reg_o,
                     rd_addr_exmem_reg_o);
            errors++;
        end
    endtask

    task automatic test_branch();
        set_instr(OP_BLT, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 5'd0, 1'b0, 1'b0);
        #1;
        tests++;
        if (branch_taken_o !== 1'b1 || branch_target_o !== 32'h120) begin
            $display("FAIL blt: got taken=%b target=%h expected 1 00000120", branch_taken_o,
                     branch_target_o);
            errors++;
        end
        operation_idex_reg_i = OP_BLTU;
        #1;
        tests++;
        if (branch_taken_o !== 1'b0) begin
            $display("FAIL bltu: got taken=%b expected 0", branch_taken_o); errors++;
        end
        set_instr(OP_BEQ, 32'h55, 32'h55, 32'h8, 32'h10, 5'd0, 1'b0, 1'b0);
        #1;
        tests++;
        if (branch_taken_o !== 1'b1 || branch_target_o !== 32'h18) begin
            $display("FAIL beq: got taken=%b target=%h expected 1 00000018", branch_taken_o,
                     branch_target_o);
            errors++;
        end
        valid_idex_reg_i = 1'b0;
        #1;
        tests++;
        if (branch_taken_o !== 1'b0) begin
            $display("FAIL beq_invalid: got taken=%b expected 0", branch_taken_o); errors++;
        end
        set_instr(OP_JAL, 32'h0, 32'h0, 32'h10, 32'h40, 5'd1, 1'b0, 1'b1);
        #1;
        tests++;
        if (branch_taken_o !== 1'b1 || branch_target_o !== 32'h50) begin
            $display("FAIL jal_target: got taken=%b target=%h expected 1 00000050",
                     branch_taken_o, branch_target_o);
            errors++;
        end
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'h44) begin
            $display("FAIL jal_link: got %h expected 00000044", alu_rslt_exmem_reg_o); errors++;
        end
    endtask

    task automatic test_jalr();
        set_instr(OP_JALR, 32'h1003, 32'h0, 32'h0, 32'h300, 5'd1, 1'b0, 1'b1);
        #1;
        tests++;
        if (branch_taken_o !== 1'b1 || branch_target_o !== 32'h1002) begin
            $display("FAIL jalr_target: got taken=%b target=%h expected 1 00001002",
                     branch_taken_o, branch_target_o);
            errors++;
        end
        tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'h304) begin
            $display("FAIL jalr_link: got %h expected 00000304", alu_rslt_exmem_reg_o); errors++;
        end
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expected);
        int edges = 0;
        int stall_cycles = 0;
        int bubble_bad = 0;
        logic was_stalled;
        set_instr(OP_ADD, 32'h10, 32'h1, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1);
        tick();
        set_instr(OP_MUL, a, b, 32'h0, 32'h0, 5'd9, 1'b0, 1'b1);
        #1;
        tests++;
        if (stall_o !== 1'b1 || branch_taken_o !== 1'b0) begin
            $display("FAIL %s_issue_stall: got stall=%b taken=%b expected 1 0", name, stall_o,
                     branch_taken_o);
            errors++;
        end
        while (edges < 40) begin
            was_stalled = stall_o;
            if (was_stalled) stall_cycles++;
            tick();
            edges++;
            if (!was_stalled) break;
            if (regfile_wr_en_exmem_reg_o !== 1'b0 || alu_rslt_exmem_reg_o !== 32'h11)
                bubble_bad++;
        end
        valid_idex_reg_i = 1'b0;
        tests++;
        if (edges != 33 || stall_cycles != 32) begin
            $display("FAIL %s_latency: got edges=%0d stall_cycles=%0d expected 33 32", name,
                     edges, stall_cycles);
            errors++;
        end
        tests++;
        if (bubble_bad != 0) begin
            $display("FAIL %s_bubbles: got %0d bad bubble cycles expected 0", name, bubble_bad);
            errors++;
        end
        tests++;
        if (alu_rslt_exmem_reg_o !== expected || regfile_wr_en_exmem_reg_o !== 1'b1 ||
            rd_addr_exmem_reg_o !== 5'd9 || operation_exmem_reg_o !== OP_MUL) begin
            $display("FAIL %s_result: got %h rf=%b rd=%0d expected %h rf=1 rd=9", name,
                     alu_rslt_exmem_reg_o, regfile_wr_en_exmem_reg_o, rd_addr_exmem_reg_o,
                     expected);
            errors++;
        end
    endtask

    task automatic test_mul_reset();
        set_instr(OP_MUL, 32'd7, 32'd6, 32'h0, 32'h0, 5'd9, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (stall_o !== 1'b1) begin
            $display("FAIL mulrst_busy: got stall=%b expected 1", stall_o); errors++;
        end
        #2;
        rst_ni           = 1'b0;
        valid_idex_reg_i = 1'b0;
        #1;
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'd0 || regfile_wr_en_exmem_reg_o !== 1'b0 ||
            rd_addr_exmem_reg_o !== 5'd0 || operation_exmem_reg_o !== 5'd0 || stall_o !== 1'b0) begin
            $display("FAIL mulrst_clear: got alu=%h rf=%b rd=%0d stall=%b expected all 0",
                     alu_rslt_exmem_reg_o, regfile_wr_en_exmem_reg_o, rd_addr_exmem_reg_o, stall_o);
            errors++;
        end
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'd0 || regfile_wr_en_exmem_reg_o !== 1'b0 || stall_o !== 1'b0) begin
            $display("FAIL mulrst_no_result: got alu=%h rf=%b stall=%b expected 0 0 0",
                     alu_rslt_exmem_reg_o, regfile_wr_en_exmem_reg_o, stall_o);
            errors++;
        end
        set_instr(OP_ADD, 32'd2, 32'd3, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1);
        tick();
        valid_idex_reg_i = 1'b0;
        tests++;
        if (alu_rslt_exmem_reg_o !== 32'd5 || regfile_wr_en_exmem_reg_o !== 1'b1) begin
            $display("FAIL mulrst_next_add: got %h rf=%b expected 00000005 rf=1",
                     alu_rslt_exmem_reg_o, regfile_wr_en_exmem_reg_o);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_alu_ops();
        test_bubble();
        test_branch();
        test_jalr();
        run_mul("mul", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        run_mul("mul_zero", 32'h0001_2345, 32'd0, 32'd0);
        test_mul_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
